// File: rtl/baud_pkg.sv
// ---------------------------------------------------------------------------
// baud_pkg
//   Shared constants for the fractional-N baud tick generator.
//   BAUD_SEL_W  : width of the baud_select code
//   BAUD_NUM    : number of table entries
//   BAUD_TABLE  : baud rate selected by each baud_select code
//   inc_calc()  : phase increment = round(baud * os * 2^acc_w / clk_hz)
// ---------------------------------------------------------------------------
package baud_pkg;

    localparam int BAUD_SEL_W = 3;
    localparam int BAUD_NUM   = 1 << BAUD_SEL_W;

    localparam int unsigned BAUD_TABLE [0:BAUD_NUM-1] = '{
        300, 1200, 4800, 9600, 19200, 38400, 57600, 115200
    };

    // Rounded to nearest: (2*num + clk) / (2*clk) avoids needing clk to be even.
    function automatic longint unsigned inc_calc(
        input longint unsigned baud,
        input longint unsigned clk_hz,
        input longint unsigned os,
        input longint unsigned acc_w
    );
        longint unsigned num;
        num = (baud * os) << acc_w;
        return (2 * num + clk_hz) / (2 * clk_hz);
    endfunction

endpackage

// File: rtl/baud_phase_acc.sv
// ---------------------------------------------------------------------------
// baud_phase_acc
//   Phase accumulator with registered carry-out. Every enabled cycle the
//   increment is added modulo 2^ACC_W; the residue is kept so the average
//   carry rate is exactly inc / 2^ACC_W per cycle.
//   Ports:
//     clk, reset : clock, asynchronous active-high reset
//     en         : 1 = accumulate, 0 = hold accumulator and carry
//     clr        : clear accumulator and carry (wins over en)
//     inc        : phase increment
//     carry      : registered carry of the last accumulate
// ---------------------------------------------------------------------------
module baud_phase_acc
    import baud_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [ACC_W-1:0] inc,
    output logic             carry
);

    logic [ACC_W-1:0] acc_reg;
    logic             carry_reg;
    logic [ACC_W:0]   sum_next;

    assign sum_next = {1'b0, acc_reg} + {1'b0, inc};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg   <= '0;
            carry_reg <= 1'b0;
        end else if (clr) begin
            acc_reg   <= '0;
            carry_reg <= 1'b0;
        end else if (en) begin
            acc_reg   <= sum_next[ACC_W-1:0];
            carry_reg <= sum_next[ACC_W];
        end
    end

    assign carry = carry_reg;

endmodule

// File: rtl/baud_tick_generator.sv
// ---------------------------------------------------------------------------
// baud_tick_generator
//   Fractional-N baud tick source. A phase accumulator produces os_tick at
//   baud*OVERSAMPLE; an oversample counter decodes mid_tick (mid-bit) and
//   bit_tick (bit boundary). resync restarts the bit phase at 0.
//   Ports:
//     clk, reset  : clock, asynchronous active-high reset
//     enable      : 1 = run, 0 = hold all state and suppress ticks
//     baud_select : 0..7 -> 300 .. 115200 baud
//     resync      : one-cycle pulse, restart bit phase
//     inc_wr      : (BAUD_RUNTIME_INC_EN only) load runtime increment
//     inc_val     : (BAUD_RUNTIME_INC_EN only) runtime increment, 0 = use table
//     os_tick     : oversample tick
//     mid_tick    : os_tick at os_cnt == OVERSAMPLE/2-1
//     bit_tick    : os_tick at os_cnt == OVERSAMPLE-1 (wrap to 0)
//     os_cnt      : current oversample index
//   Optional feature macro: BAUD_RUNTIME_INC_EN
// ---------------------------------------------------------------------------
module baud_tick_generator
    import baud_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int OVERSAMPLE  = 16,
    parameter int ACC_W       = 24
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [BAUD_SEL_W-1:0]         baud_select,
    input  logic                          resync,
`ifdef BAUD_RUNTIME_INC_EN
    input  logic                          inc_wr,
    input  logic [ACC_W-1:0]              inc_val,
`endif
    output logic                          os_tick,
    output logic                          mid_tick,
    output logic                          bit_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] os_cnt
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] MID_IDX  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OVERSAMPLE - 1);

    if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4 || OVERSAMPLE > 64) begin : g_os_err
        $error("OVERSAMPLE must be even and within 4..64");
    end

    // Increment table evaluated at elaboration from the clock frequency.
    logic [ACC_W-1:0] inc_tab [0:BAUD_NUM-1];

    for (genvar gi = 0; gi < BAUD_NUM; gi++) begin : g_inc
        localparam longint unsigned INC_G =
            inc_calc(BAUD_TABLE[gi], CLK_FREQ_HZ, OVERSAMPLE, ACC_W);
        if (INC_G == 0 || INC_G >= (64'd1 << ACC_W)) begin : g_inc_err
            $error("baud increment out of range for table entry %0d", gi);
        end
        assign inc_tab[gi] = INC_G[ACC_W-1:0];
    end

    logic [BAUD_SEL_W-1:0] sel_reg;
    logic                  rate_change;
    logic                  clr;
    logic [ACC_W-1:0]      inc;
    logic                  carry;
    logic [CNT_W-1:0]      cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_reg <= '0;
        end else begin
            sel_reg <= baud_select;
        end
    end

    assign rate_change = (baud_select != sel_reg);

`ifdef BAUD_RUNTIME_INC_EN
    logic             ovr_reg;
    logic [ACC_W-1:0] inc_reg;

    // A write of 0 drops back to the table; a write takes priority over a
    // simultaneous baud_select change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr_reg <= 1'b0;
            inc_reg <= '0;
        end else if (inc_wr) begin
            ovr_reg <= |inc_val;
            inc_reg <= inc_val;
        end else if (rate_change) begin
            ovr_reg <= 1'b0;
        end
    end

    assign clr = resync | rate_change | inc_wr;
    assign inc = ovr_reg ? inc_reg : inc_tab[sel_reg];
`else
    assign clr = resync | rate_change;
    assign inc = inc_tab[sel_reg];
`endif

    baud_phase_acc #(
        .ACC_W (ACC_W)
    ) u_phase_acc (
        .clk   (clk),
        .reset (reset),
        .en    (enable),
        .clr   (clr),
        .inc   (inc),
        .carry (carry)
    );

    // The carry is held while disabled, so a tick due at freeze time is
    // delivered on the first enabled cycle rather than lost or duplicated.
    assign os_tick = carry & enable & ~clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (os_tick) begin
            cnt_reg <= (cnt_reg == LAST_IDX) ? '0 : cnt_reg + CNT_W'(1);
        end
    end

    assign os_cnt   = cnt_reg;
    assign mid_tick = os_tick & (cnt_reg == MID_IDX);
    assign bit_tick = os_tick & (cnt_reg == LAST_IDX);

endmodule

// File: tb/tb_baud_tick_generator.sv
module tb_baud_tick_generator;

    localparam int  OS   = 16;
    localparam int  W    = 24;
    localparam real CLKF = 50000000.0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [2:0] baud_select = 3'd7;
    logic       resync = 1'b0;
`ifdef BAUD_RUNTIME_INC_EN
    logic          inc_wr = 1'b0;
    logic [W-1:0]  inc_val = '0;
`endif
    logic       os_tick, mid_tick, bit_tick;
    logic [3:0] os_cnt;

    baud_tick_generator #(
        .CLK_FREQ_HZ (50000000),
        .OVERSAMPLE  (OS),
        .ACC_W       (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .baud_select (baud_select),
        .resync      (resync),
`ifdef BAUD_RUNTIME_INC_EN
        .inc_wr      (inc_wr),
        .inc_val     (inc_val),
`endif
        .os_tick     (os_tick),
        .mid_tick    (mid_tick),
        .bit_tick    (bit_tick),
        .os_cnt      (os_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: elapsed accumulate steps since the last clear, with a
    // carry due whenever n*inc crosses a multiple of 2^W.
    int     bauds [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};
    longint tb_inc [8];
    longint m_n     = 0;
    bit     m_due   = 0;
    longint m_ticks = 0;
    int     m_sel   = 0;
`ifdef BAUD_RUNTIME_INC_EN
    bit     m_ovr     = 0;
    longint m_ovr_val = 0;
`endif

    function automatic longint cur_inc();
`ifdef BAUD_RUNTIME_INC_EN
        if (m_ovr) return m_ovr_val;
`endif
        return tb_inc[m_sel];
    endfunction

    // Observed event counters and spacing tracking.
    longint cyc = 0;
    int     os_count = 0, mid_count = 0, bit_count = 0;
    longint last_tick = -1;
    bit     spc_en = 0;
    int     spc_lo = 27;

    always @(negedge clk) begin
        logic [6:0] got_v, exp_v;
        bit         clr_e, t_e;
        int         cnt_e;
        longint     inc_c, gap;
        got_v = {os_tick, mid_tick, bit_tick, os_cnt};
        cyc++;
        if (reset) begin
            check("reset_out", 64'(got_v), 64'd0);
            m_n = 0; m_due = 0; m_ticks = 0; m_sel = 0; last_tick = -1;
`ifdef BAUD_RUNTIME_INC_EN
            m_ovr = 0; m_ovr_val = 0;
`endif
        end else begin
            clr_e = resync || (int'(baud_select) != m_sel);
`ifdef BAUD_RUNTIME_INC_EN
            clr_e = clr_e || inc_wr;
`endif
            t_e   = m_due && enable && !clr_e;
            cnt_e = int'(m_ticks % OS);
            exp_v = {t_e, t_e && (cnt_e == OS/2-1), t_e && (cnt_e == OS-1), 4'(cnt_e)};
            check("cycle_out", 64'(got_v), 64'(exp_v));

            if (os_tick) begin
                os_count++;
                if (spc_en && last_tick >= 0) begin
                    gap = cyc - last_tick;
                    check("os_gap", 64'(gap), (gap <= spc_lo) ? 64'(spc_lo) : 64'(spc_lo + 1));
                end
                last_tick = cyc;
            end
            if (mid_tick) mid_count++;
            if (bit_tick) bit_count++;

            inc_c = cur_inc();
            if (clr_e) begin
`ifdef BAUD_RUNTIME_INC_EN
                if (inc_wr) begin
                    m_ovr = (inc_val != 0);
                    m_ovr_val = longint'(inc_val);
                end else if (int'(baud_select) != m_sel) begin
                    m_ovr = 0;
                end
`endif
                m_n = 0; m_due = 0; m_ticks = 0; last_tick = -1;
            end else begin
                if (t_e) m_ticks++;
                if (enable) begin
                    m_n++;
                    m_due = ((m_n * inc_c) >> W) != (((m_n - 1) * inc_c) >> W);
                end
            end
            m_sel = int'(baud_select);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mid(input int max_cyc);
        int start;
        start = mid_count;
        for (int i = 0; i < max_cyc && mid_count == start; i++) step();
        if (mid_count == start) check("mid_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_bit(input int max_cyc);
        int start;
        start = bit_count;
        for (int i = 0; i < max_cyc && bit_count == start; i++) step();
        if (bit_count == start) check("bit_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int os0;
        for (int s = 0; s < 8; s++)
            tb_inc[s] = longint'($rtoi(real'(bauds[s]) * OS * (2.0 ** W) / CLKF + 0.5));

        // Reset state
        repeat (3) step();
        check("reset_cnt", 64'(os_cnt), 64'd0);
        reset = 1'b0;
        $display("phase reset: checks=%0d", n_checks);

        // Long-run rate at 115200 and tick spacing of 27/28 cycles
        spc_en = 1; spc_lo = 27;
        os0 = os_count;
        repeat (20000) step();
        begin
            int d;
            d = os_count - os0;
            check("os_rate_115200", 64'(d), (d < 736) ? 64'd736 : (d > 738) ? 64'd738 : 64'(d));
        end
        $display("phase rate: os_ticks=%0d checks=%0d", os_count - os0, n_checks);

        // resync: os_cnt 0 next cycle, mid after 8 os_ticks, bit after 16
        wait_mid(2000);
        repeat (3) step();
        resync = 1'b1;
        step();
        resync = 1'b0;
        check("resync_cnt", 64'(os_cnt), 64'd0);
        os0 = os_count;
        wait_mid(2000);
        check("resync_mid_after", 64'(os_count - os0), 64'd8);
        wait_bit(2000);
        check("resync_bit_after", 64'(os_count - os0), 64'd16);
        $display("phase resync: checks=%0d", n_checks);

        // enable low for 1000 cycles mid-bit
        spc_en = 0;
        wait_mid(2000);
        repeat (2) step();
        enable = 1'b0;
        os0 = os_count;
        repeat (1000) step();
        check("en_off_ticks", 64'(os_count - os0), 64'd0);
        check("en_hold_cnt", 64'(os_cnt), 64'(m_ticks % OS));
        enable = 1'b1;
        repeat (500) step();
        $display("phase enable: checks=%0d", n_checks);

        // Rate change 7 -> 3 mid-bit, then 325/326 spacing
        spc_en = 1; spc_lo = 27;
        wait_mid(2000);
        repeat (3) step();
        baud_select = 3'd3; spc_lo = 325;
        repeat (1500) step();
        $display("phase rate_change: checks=%0d", n_checks);
        spc_en = 0;
        baud_select = 3'd7; spc_lo = 27;
        repeat (200) step();

        // Reset between mid_tick and bit_tick
        wait_mid(2000);
        repeat (2) step();
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset_out", 64'({os_tick, mid_tick, bit_tick, os_cnt}), 64'd0);
        repeat (3) step();
        reset = 1'b0;
        os0 = os_count;
        wait_bit(2000);
        check("rst_bit_after", 64'(os_count - os0), 64'd16);
        $display("phase reset_mid_bit: checks=%0d", n_checks);

        // Randomized traffic: rate changes, resync pulses, enable gaps
        for (int i = 0; i < 30000; i++) begin
            step();
            resync = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 2999) == 0) baud_select = 3'($urandom_range(4, 7));
            if (enable && $urandom_range(0, 499) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
        end
        resync = 1'b0; enable = 1'b1;
        $display("phase random: checks=%0d", n_checks);

`ifdef BAUD_RUNTIME_INC_EN
        inc_val = W'($urandom_range(100000, 900000));
        inc_wr = 1'b1;
        step();
        inc_wr = 1'b0;
        repeat (3000) step();
        inc_val = W'(1);
        inc_wr = 1'b1;
        step();
        inc_wr = 1'b0;
        os0 = os_count;
        repeat (2000) step();
        check("ovr_slow_ticks", 64'(os_count - os0), 64'd0);
        baud_select = 3'd6;
        repeat (2000) step();
        $display("phase runtime_inc: checks=%0d", n_checks);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
